// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: funnels N cores' memory requests onto one downstream port, one grant at a time.
// Define ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-first priority.
module mem_req_arbiter #(
    parameter int N      = 2,
    parameter int XLEN   = 32,
    parameter int CLSIZE = 128
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N-1:0]        core_strobe_i,
    input  logic [N*XLEN-1:0]   core_addr_i,
    input  logic [N-1:0]        core_rw_i,
    input  logic [N*CLSIZE-1:0] core_data_i,
    input  logic [N-1:0]        core_is_amo_i,
    input  logic [N*5-1:0]      core_amo_type_i,
    output logic [N-1:0]        core_done_o,
    output logic [CLSIZE-1:0]   core_data_o,
    output logic [N-1:0]        M_core_id_o,
    output logic                M_strobe_o,
    output logic [XLEN-1:0]     M_addr_o,
    output logic                M_rw_o,
    output logic [CLSIZE-1:0]   M_data_o,
    output logic                M_is_amo_o,
    output logic [4:0]          M_amo_type_o,
    input  logic                M_done_i,
    input  logic [CLSIZE-1:0]   M_data_i
);
    localparam int PW  = N > 1 ? $clog2(N) : 1;
    localparam int PW1 = PW + 1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
    state_e            state_q;
    logic [N-1:0]      pend_q, pend_d, grant_q, clr, set, rot, rw_q, amo_q;
    logic [XLEN-1:0]   addr_q [N];
    logic [CLSIZE-1:0] data_q [N];
    logic [4:0]        type_q [N];
    logic [PW-1:0]     base, sel;
    logic [PW1-1:0]    off, sum;
    logic              fire;
    assign fire        = state_q != IDLE && M_done_i;
    assign clr         = fire ? grant_q : '0;
    // a core completing this cycle may re-request in the same cycle; the new request wins
    assign set         = core_strobe_i & (~pend_q | clr);
    assign pend_d      = (pend_q & ~clr) | set;
    assign M_strobe_o  = state_q == ISSUE;
    assign M_core_id_o = grant_q;
    assign core_done_o = clr;
    assign core_data_o = fire ? M_data_i : '0;
`ifdef ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [PW-1:0] rr_q, gidx_q;
    assign base = rr_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q   <= '0;
            gidx_q <= '0;
        end else begin
            if (state_q == IDLE && |pend_q) gidx_q <= sel;
            if (fire) rr_q <= gidx_q == PW'(N - 1) ? '0 : gidx_q + PW'(1);
        end
    end
`endif
    // rotate pending so bit 0 is the core at base, take the lowest set bit, then un-rotate
    always_comb begin
        rot = N'({pend_q, pend_q} >> base);
        off = '0;
        for (int i = N - 1; i >= 0; i--) off = rot[i] ? PW1'(i) : off;
        sum = PW1'(base) + off;
        sel = PW'(sum >= PW1'(N) ? sum - PW1'(N) : sum);
    end
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < N; k++) begin
            if (set[k]) begin
                addr_q[k] <= core_addr_i[k*XLEN +: XLEN];
                data_q[k] <= core_data_i[k*CLSIZE +: CLSIZE];
                type_q[k] <= core_amo_type_i[k*5 +: 5];
                rw_q[k]   <= core_rw_i[k];
                amo_q[k]  <= core_is_amo_i[k];
            end
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            grant_q      <= '0;
            M_addr_o     <= '0;
            M_rw_o       <= 1'b0;
            M_data_o     <= '0;
            M_is_amo_o   <= 1'b0;
            M_amo_type_o <= '0;
        end else begin
            pend_q <= pend_d;
            if (state_q == IDLE) begin
                if (|pend_q) begin
                    state_q      <= ISSUE;
                    grant_q      <= N'(1) << sel;
                    M_addr_o     <= addr_q[sel];
                    M_rw_o       <= rw_q[sel];
                    M_data_o     <= data_q[sel];
                    M_is_amo_o   <= amo_q[sel];
                    M_amo_type_o <= type_q[sel];
                end
            end else if (M_done_i) begin
                state_q <= IDLE;
                grant_q <= '0;
            end else begin
                state_q <= WAIT;
            end
        end
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed stimulus checked every cycle against a behavioural arbiter model.
// Honours ARB_FIXED_PRIO_EN in both the model and the literal grant-order expectations.
`timescale 1ns/1ps
module tb_mem_req_arbiter;
    localparam int N = 2, XLEN = 32, CLSIZE = 128;
`ifdef ARB_FIXED_PRIO_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif
    logic                clk_i = 1'b0, rst_ni = 1'b0;
    logic [N-1:0]        core_strobe_i = '0, core_rw_i = '0, core_is_amo_i = '0;
    logic [N*XLEN-1:0]   core_addr_i = '0;
    logic [N*CLSIZE-1:0] core_data_i = '0;
    logic [N*5-1:0]      core_amo_type_i = '0;
    logic [N-1:0]        core_done_o, M_core_id_o;
    logic [CLSIZE-1:0]   core_data_o, M_data_o, M_data_i = '0;
    logic                M_strobe_o, M_rw_o, M_is_amo_o, M_done_i = 1'b0;
    logic [XLEN-1:0]     M_addr_o;
    logic [4:0]          M_amo_type_o;
    int n_chk = 0, n_pass = 0;

    mem_req_arbiter #(.N(N), .XLEN(XLEN), .CLSIZE(CLSIZE)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .core_strobe_i(core_strobe_i), .core_addr_i(core_addr_i),
        .core_rw_i(core_rw_i), .core_data_i(core_data_i), .core_is_amo_i(core_is_amo_i),
        .core_amo_type_i(core_amo_type_i), .core_done_o(core_done_o), .core_data_o(core_data_o),
        .M_core_id_o(M_core_id_o), .M_strobe_o(M_strobe_o), .M_addr_o(M_addr_o), .M_rw_o(M_rw_o),
        .M_data_o(M_data_o), .M_is_amo_o(M_is_amo_o), .M_amo_type_o(M_amo_type_o),
        .M_done_i(M_done_i), .M_data_i(M_data_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string nm, input logic [CLSIZE-1:0] act, input logic [CLSIZE-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    // Model: which core is being served (-1 = none), whether this is its first cycle, pending set, buffers.
    int g = -1, rr = 0;
    bit iss;
    bit pend [N];
    logic [XLEN-1:0]   b_addr [N];
    logic [CLSIZE-1:0] b_data [N];
    logic [4:0]        b_typ [N];
    logic              b_rw [N], b_amo [N];
    logic [N-1:0]      oh;

    function automatic int pick();
        for (int i = 0; i < N; i++) begin
            int j;
            j = FP ? i : (rr + i) % N;
            if (pend[j]) return j;
        end
        return -1;
    endfunction

    always begin
        @(negedge clk_i);
        #4;
        if (!rst_ni) begin
            check("rst_out", {M_core_id_o, M_strobe_o, core_done_o, M_addr_o, M_rw_o, M_is_amo_o, M_amo_type_o}, '0);
            check("rst_data", core_data_o | M_data_o, '0);
            g = -1;
            rr = 0;
            iss = 0;
            for (int k = 0; k < N; k++) pend[k] = 0;
        end else begin
            oh = g < 0 ? '0 : N'(1) << g;
            check("cyc_ctl", {M_core_id_o, M_strobe_o, core_done_o}, {oh, g >= 0 && iss, M_done_i ? oh : N'(0)});
            check("cyc_rdata", core_data_o, (g >= 0 && M_done_i) ? M_data_i : '0);
            if (g >= 0) begin
                check("cyc_fld", {M_addr_o, M_rw_o, M_is_amo_o, M_amo_type_o}, {b_addr[g], b_rw[g], b_amo[g], b_typ[g]});
                check("cyc_wdata", M_data_o, b_data[g]);
            end
            if (g < 0) begin
                g = pick();
                iss = g >= 0;
            end else if (M_done_i) begin
                pend[g] = 0;
                rr = (g + 1) % N;
                g = -1;
                iss = 0;
            end else begin
                iss = 0;
            end
            for (int k = 0; k < N; k++) begin
                if (core_strobe_i[k] && !pend[k]) begin
                    pend[k] = 1;
                    b_addr[k] = core_addr_i[k*XLEN +: XLEN];
                    b_data[k] = core_data_i[k*CLSIZE +: CLSIZE];
                    b_typ[k] = core_amo_type_i[k*5 +: 5];
                    b_rw[k] = core_rw_i[k];
                    b_amo[k] = core_is_amo_i[k];
                end
            end
        end
    end

    task automatic nxt();
        @(negedge clk_i);
        core_strobe_i = '0;
        M_done_i = 1'b0;
    endtask

    task automatic smp();
        #4;
    endtask

    task automatic req(input int k, input logic [XLEN-1:0] a, input logic rw, input logic amo,
                       input logic [4:0] t, input logic [CLSIZE-1:0] d);
        core_strobe_i[k] = 1'b1;
        core_addr_i[k*XLEN +: XLEN] = a;
        core_rw_i[k] = rw;
        core_is_amo_i[k] = amo;
        core_amo_type_i[k*5 +: 5] = t;
        core_data_i[k*CLSIZE +: CLSIZE] = d;
    endtask

    task automatic wait_issue(input string nm, input logic [N-1:0] id, input logic [XLEN-1:0] a, output int k);
        k = 0;
        while (M_strobe_o !== 1'b1 && k < 20) begin
            nxt();
            smp();
            k++;
        end
        check({nm, "_stb"}, M_strobe_o, 1);
        check({nm, "_id"}, M_core_id_o, id);
        check({nm, "_addr"}, M_addr_o, a);
    endtask

    task automatic complete(input string nm, input int lat, input logic [CLSIZE-1:0] rd, input logic [N-1:0] id);
        repeat (lat) begin
            nxt();
            smp();
        end
        nxt();
        M_done_i = 1'b1;
        M_data_i = rd;
        smp();
        check({nm, "_done"}, core_done_o, id);
        check({nm, "_rdata"}, core_data_o, rd);
        nxt();
        smp();
        check({nm, "_gap"}, M_core_id_o, 0);
    endtask

    task automatic serve(input string nm, input logic [N-1:0] id, input logic [XLEN-1:0] a,
                         input int lat, input logic [CLSIZE-1:0] rd);
        int k;
        wait_issue(nm, id, a, k);
        complete(nm, lat, rd, id);
    endtask

    task automatic do_reset();
        nxt();
        rst_ni = 1'b0;
        smp();
        nxt();
        rst_ni = 1'b1;
        smp();
    endtask

    initial begin
        int k;
        logic [N-1:0] eid;
        nxt();
        smp();
        check("reset_ctl", {M_core_id_o, M_strobe_o, core_done_o}, 0);
        nxt();
        rst_ni = 1'b1;
        smp();
        // single request: issued two cycles after the strobe, done three cycles after issue
        nxt();
        req(0, 32'h1000, 1'b0, 1'b0, 5'd0, '0);
        smp();
        wait_issue("t1", 2'b01, 32'h1000, k);
        check("t1_lat", k, 2);
        complete("t1", 2, {4{32'hA5A5A5A5}}, 2'b01);
        // simultaneous pairs: order depends on the rotating pointer
        do_reset();
        nxt();
        req(0, 32'h100, 1'b0, 1'b0, 5'd0, 128'h11);
        req(1, 32'h200, 1'b1, 1'b0, 5'd0, 128'h22);
        smp();
        serve("p1a", 2'b01, 32'h100, 0, 128'hAAAA);
        serve("p1b", 2'b10, 32'h200, 1, 128'hBBBB);
        nxt();
        req(0, 32'h250, 1'b0, 1'b0, 5'd0, 128'h33);
        smp();
        serve("s0", 2'b01, 32'h250, 0, 128'hCCCC);
        nxt();
        req(0, 32'h300, 1'b0, 1'b0, 5'd0, 128'h44);
        req(1, 32'h400, 1'b0, 1'b0, 5'd0, 128'h55);
        smp();
        serve("p2a", FP ? 2'b01 : 2'b10, FP ? 32'h300 : 32'h400, 0, 128'hDDDD);
        serve("p2b", FP ? 2'b10 : 2'b01, FP ? 32'h400 : 32'h300, 0, 128'hEEEE);
        // AMO fields held through WAIT while another core strobes
        nxt();
        req(1, 32'h40, 1'b1, 1'b1, 5'b00000, {32'h5, 96'h0});
        smp();
        wait_issue("amo", 2'b10, 32'h40, k);
        nxt();
        req(0, 32'h80, 1'b0, 1'b0, 5'h1f, 128'h77);
        smp();
        check("amo_hold", {M_core_id_o, M_is_amo_o, M_amo_type_o, M_strobe_o, M_addr_o}, {2'b10, 1'b1, 5'b0, 1'b0, 32'h40});
        check("amo_wdata", M_data_o, {32'h5, 96'h0});
        complete("amo", 1, 128'h1234, 2'b10);
        serve("amo_c0", 2'b01, 32'h80, 0, 128'h5678);
        // done already present in the ISSUE cycle
        nxt();
        req(1, 32'h60, 1'b0, 1'b0, 5'd0, '0);
        smp();
        nxt();
        smp();
        nxt();
        M_done_i = 1'b1;
        M_data_i = 128'h9999;
        smp();
        check("iss_done", {M_strobe_o, core_done_o, M_core_id_o}, {1'b1, 2'b10, 2'b10});
        nxt();
        smp();
        check("iss_gap", M_core_id_o, 0);
        // duplicate strobe while pending is ignored
        nxt();
        req(0, 32'h10, 1'b0, 1'b0, 5'd0, '0);
        smp();
        nxt();
        req(0, 32'h20, 1'b0, 1'b0, 5'd0, '0);
        smp();
        serve("dup", 2'b01, 32'h10, 1, 128'h4242);
        repeat (4) begin
            nxt();
            smp();
            check("dup_none", {M_strobe_o, M_core_id_o}, 0);
        end
        // asynchronous reset during WAIT abandons everything
        nxt();
        req(1, 32'h90, 1'b0, 1'b0, 5'd0, '0);
        smp();
        wait_issue("rst", 2'b10, 32'h90, k);
        nxt();
        req(0, 32'h94, 1'b0, 1'b0, 5'd0, '0);
        smp();
        nxt();
        #1 rst_ni = 1'b0;
        #1;
        check("rst_async", {M_core_id_o, M_strobe_o, core_done_o, M_addr_o}, 0);
        nxt();
        rst_ni = 1'b1;
        M_done_i = 1'b1;
        M_data_i = 128'hDEAD;
        smp();
        check("rst_nodone", {core_done_o, core_data_o}, 0);
        repeat (3) begin
            nxt();
            smp();
            check("rst_lost", {M_strobe_o, M_core_id_o}, 0);
        end
        // both cores continuously pending, re-strobing in each done cycle
        do_reset();
        nxt();
        req(0, 32'hA0, 1'b0, 1'b0, 5'd0, '0);
        req(1, 32'hB0, 1'b0, 1'b0, 5'd0, '0);
        smp();
        for (int t = 0; t < 4; t++) begin
            eid = (FP || t % 2 == 0) ? 2'b01 : 2'b10;
            wait_issue("fair", eid, eid == 2'b01 ? 32'hA0 : 32'hB0, k);
            nxt();
            M_done_i = 1'b1;
            M_data_i = CLSIZE'(t + 1);
            req(0, 32'hA0, 1'b0, 1'b0, 5'd0, '0);
            req(1, 32'hB0, 1'b0, 1'b0, 5'd0, '0);
            smp();
            check("fair_done", core_done_o, eid);
        end
        nxt();
        smp();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Arbitrates data-memory requests from N cores onto the single request port of the atomic/LR-SC unit.
- Captures each core's request into a per-core pending buffer.
- Grants one core at a time, round-robin, and drives that core's one-hot ID plus its request fields downstream.
- Holds the downstream fields stable until the done signal comes back, then returns done and read data to the granted core only.

Parameters:
- N, 2: number of cores, 1..8.
- XLEN, 32: address width.
- CLSIZE, 128: cache-line data width in bits.

Ports:
- clk_i  in  1  clock; one clock; reset is asynchronous and active-low.
- rst_ni  in  1  asynchronous active-low reset.
- core_strobe_i  in  N  per-core one-cycle request pulse.
- core_addr_i  in  N*XLEN  per-core address; core k occupies bits [k*XLEN +: XLEN].
- core_rw_i  in  N  per-core access type; 1 = write.
- core_data_i  in  N*CLSIZE  per-core write data / AMO operand.
- core_is_amo_i  in  N  per-core atomic flag.
- core_amo_type_i  in  N*5  per-core AMO funct5.
- core_done_o  out  N  per-core completion pulse.
- core_data_o  out  CLSIZE  read data, shared by all cores; valid when that core's core_done_o is high.
- M_core_id_o  out  N  one-hot ID of the granted core; 0 when idle.
- M_strobe_o  out  1  downstream request pulse.
- M_addr_o  out  XLEN  downstream address.
- M_rw_o  out  1  downstream access type.
- M_data_o  out  CLSIZE  downstream write data.
- M_is_amo_o  out  1  downstream atomic flag.
- M_amo_type_o  out  5  downstream AMO funct5.
- M_done_i  in  1  downstream completion.
- M_data_i  in  CLSIZE  downstream read data.

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - State = IDLE; pending[] = 0; rr_ptr = 0; grant = 0.
  - All M_* outputs 0; core_done_o = 0; core_data_o = 0.
- Capture:
  - core_strobe_i[k] at edge t sets pending[k] and latches that core's addr, rw, data, is_amo and amo_type.
  - A strobe while pending[k] is already 1 is ignored; the buffer is not overwritten.
- FSM, IDLE:
  - If any pending bit is set, choose the first pending index at or after rr_ptr (wrapping modulo N).
  - Register grant, load the M_* field registers from that core's buffer, go to ISSUE.
  - A request captured at edge t is issued at edge t+1 at the earliest, so M_strobe_o is high in cycle t+1 to t+2.
- FSM, ISSUE:
  - M_strobe_o = 1 for exactly one cycle, then go to WAIT.
  - If M_done_i is already high in ISSUE, complete exactly as in WAIT.
- FSM, WAIT:
  - M_strobe_o = 0; all M_* fields and M_core_id_o are held stable.
  - On M_done_i: core_done_o[g] = 1 combinationally in the same cycle and core_data_o = M_data_i.
  - Same cycle: pending[g] cleared at the edge, rr_ptr = (g+1) mod N, grant cleared, go to IDLE.
- Bus turnaround:
  - M_core_id_o and the fields stay valid through the done cycle.
  - There is at least one IDLE cycle between consecutive grants.
- Simultaneous events:
  - Strobe from core g in the same cycle as its own done: set wins, and the new request is captured as pending.
  - Strobes from several cores in the same cycle: all are captured; service follows round-robin order.
- Outputs in IDLE:
  - M_core_id_o = 0 and M_strobe_o = 0; core_done_o = 0.
  - Field outputs keep their last value; they carry no meaning.
- Fairness: with every core continuously pending, each core is granted once every N transactions.
- Reset mid-transaction: the transaction is abandoned, the pending buffers are lost, and no done is issued.
- M_done_i in IDLE is ignored.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: rr_ptr is removed and the lowest-indexed pending core always wins; starvation is permitted.
- Undefined (default): round-robin as specified above.

Test Plan:
- Single request: core0 strobe with addr=0x0000_1000, rw=0, is_amo=0 -> M_strobe_o high one cycle, M_core_id_o=2'b01, M_addr_o=0x1000. M_done_i 3 cycles later with M_data_i=0xA5A5.. -> core_done_o=2'b01 and core_data_o=0xA5A5.. in the same cycle.
- Simultaneous strobes from core0 and core1 with rr_ptr=0 -> core0 served first (M_core_id_o=01), then core1 (10) after at least one IDLE cycle. A second simultaneous pair is served core1 first if rr_ptr=1, i.e. order alternates.
- AMO passthrough: core1 amoadd, amo_type=5'b00000, data=0x5 in the top 32 bits -> M_is_amo_o=1 and M_amo_type_o=0 held stable until M_done_i. Fields unchanged even if core0 strobes during WAIT.
- Duplicate strobe: core0 strobes twice before done with addr 0x10 then 0x20 -> only 0x10 is issued, with one done and no second transaction.
- Reset mid-WAIT: assert rst_ni=0 while core1 is granted -> all outputs 0 immediately (asynchronous). After release, a pulse on M_done_i produces no core_done_o.
- Compiled with ARB_FIXED_PRIO_EN: core0 and core1 pending continuously -> core0 granted every time.
